// File: rtl/pwm_counter.sv
// Purpose : PWM timebase; prescaled up/down counter with inclusive terminal count.
// Latency : one clock; a step decided on edge N shows on counter_val/tick/wrap after edge N.
// Backpr. : none; en=0 (or a one-shot stop) freezes counter and prescaler in place.
//
// Ports
//   clk, rst     : system clock, asynchronous active-high reset
//   en           : count enable (freezes counter and prescaler when low)
//   count_reset  : synchronous clear pulse; loads 0 (up) or period (down)
//   upnotdown    : 1 = count up, 0 = count down
//   period       : terminal count, inclusive
//   prescale     : one step per prescale+1 enabled clocks
//   counter_val  : registered current count
//   tick         : one-cycle pulse, counter_val has just stepped
//   wrap         : one-cycle pulse, counter_val has just wrapped (subset of tick)
//
// Optional build macro PWM_COUNTER_ONESHOT_EN adds:
//   oneshot      : stop counting after the next wrap step
//   stopped      : high once a one-shot wrap has occurred; cleared by rst/count_reset
module pwm_counter #(
  parameter int WIDTH = 16,
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             count_reset,
  input  logic             upnotdown,
  input  logic [WIDTH-1:0] period,
  input  logic [PSC_W-1:0] prescale,
`ifdef PWM_COUNTER_ONESHOT_EN
  input  logic             oneshot,
  output logic             stopped,
`endif
  output logic [WIDTH-1:0] counter_val,
  output logic             tick,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             run;        // counting allowed this cycle
  logic             step;       // prescaler has expired: move the counter
  logic [WIDTH-1:0] step_val;   // counter value after a step
  logic             step_wrap;  // that step is a wrap

`ifdef PWM_COUNTER_ONESHOT_EN
  logic stopped_q, stopped_d;
  assign run = en & ~stopped_q;
`else
  assign run = en;
`endif

  // Using >= rather than == lets a prescale lowered below the current
  // prescaler phase take effect on the very next enabled edge.
  assign step = run && (psc_q >= prescale);

  // Step target. The > period test in down mode (and >= in up mode) pulls a
  // count left above a freshly shrunk period straight back into 0..period.
  always_comb begin
    step_val  = cnt_q;
    step_wrap = 1'b0;
    if (upnotdown) begin
      if (cnt_q >= period) begin
        step_val  = '0;
        step_wrap = 1'b1;
      end else begin
        step_val  = cnt_q + WIDTH'(1);
      end
    end else begin
      if ((cnt_q == '0) || (cnt_q > period)) begin
        step_val  = period;
        step_wrap = 1'b1;
      end else begin
        step_val  = cnt_q - WIDTH'(1);
      end
    end
  end

  // Next state: count_reset beats en; otherwise advance the prescaler or step.
  always_comb begin
    cnt_d  = cnt_q;
    psc_d  = psc_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
`ifdef PWM_COUNTER_ONESHOT_EN
    stopped_d = stopped_q;
`endif
    if (count_reset) begin
      cnt_d = upnotdown ? '0 : period;
      psc_d = '0;
`ifdef PWM_COUNTER_ONESHOT_EN
      stopped_d = 1'b0;
`endif
    end else if (step) begin
      cnt_d  = step_val;
      psc_d  = '0;
      tick_d = 1'b1;
      wrap_d = step_wrap;
`ifdef PWM_COUNTER_ONESHOT_EN
      // The wrap step itself still completes and pulses; only later steps stop.
      if (oneshot && step_wrap) begin
        stopped_d = 1'b1;
      end
`endif
    end else if (run) begin
      psc_d = psc_q + PSC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      psc_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      psc_q  <= psc_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef PWM_COUNTER_ONESHOT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stopped_q <= 1'b0;
    end else begin
      stopped_q <= stopped_d;
    end
  end

  assign stopped = stopped_q;
`endif

  assign counter_val = cnt_q;
  assign tick        = tick_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_pwm_counter.sv
// Purpose : self-checking bench for pwm_counter (scoreboard plus directed checks).
// Latency : each stimulus cycle predicts one edge and compares #1 after it.
// Backpr. : none.
module tb_pwm_counter;
  localparam int WIDTH = 16;
  localparam int PSC_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             count_reset;
  logic             upnotdown;
  logic [WIDTH-1:0] period;
  logic [PSC_W-1:0] prescale;
  logic [WIDTH-1:0] counter_val;
  logic             tick;
  logic             wrap;
`ifdef PWM_COUNTER_ONESHOT_EN
  logic             oneshot;
  logic             stopped;
`endif

  always #5 clk = ~clk;

  pwm_counter #(.WIDTH(WIDTH), .PSC_W(PSC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .count_reset (count_reset),
    .upnotdown   (upnotdown),
    .period      (period),
    .prescale    (prescale),
`ifdef PWM_COUNTER_ONESHOT_EN
    .oneshot     (oneshot),
    .stopped     (stopped),
`endif
    .counter_val (counter_val),
    .tick        (tick),
    .wrap        (wrap)
  );

  typedef struct packed {
    logic [WIDTH-1:0] cnt;
    logic             tick;
    logic             wrap;
    logic             stopped;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic [WIDTH-1:0] m_cnt;
  logic [PSC_W-1:0] m_psc;
  logic             m_stop;

  int n_pass   = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic model_clear();
    m_cnt  = '0;
    m_psc  = '0;
    m_stop = 1'b0;
    sb_q.delete();
  endtask

  // Advance the model by one clock edge using the inputs now applied.
  task automatic predict();
    exp_t e;
    logic os;
    e = '0;
    os = 1'b0;
`ifdef PWM_COUNTER_ONESHOT_EN
    os = oneshot;
`endif
    if (count_reset) begin
      m_cnt  = upnotdown ? '0 : period;
      m_psc  = '0;
      m_stop = 1'b0;
    end else if (en && !m_stop) begin
      if (m_psc < prescale) begin
        m_psc = m_psc + 1'b1;
      end else begin
        m_psc  = '0;
        e.tick = 1'b1;
        if (upnotdown) begin
          if (m_cnt >= period) begin m_cnt = '0; e.wrap = 1'b1; end
          else m_cnt = m_cnt + 1'b1;
        end else begin
          if (m_cnt == 0 || m_cnt > period) begin m_cnt = period; e.wrap = 1'b1; end
          else m_cnt = m_cnt - 1'b1;
        end
        if (os && e.wrap) m_stop = 1'b1;
      end
    end
    e.cnt     = m_cnt;
    e.stopped = m_stop;
    sb_q.push_back(e);
  endtask

  // One clock: push prediction, clock, then pop and compare #1 after the edge.
  task automatic step(input string tag);
    exp_t e;
    predict();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".cnt"},  32'(counter_val), 32'(e.cnt));
    check({tag, ".tick"}, 32'(tick),        32'(e.tick));
    check({tag, ".wrap"}, 32'(wrap),        32'(e.wrap));
`ifdef PWM_COUNTER_ONESHOT_EN
    check({tag, ".stopped"}, 32'(stopped), 32'(e.stopped));
`endif
  endtask

  task automatic steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  // Assert reset between edges and check that it acts without a clock.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check({tag, ".cnt"},  32'(counter_val), 32'd0);
    check({tag, ".tick"}, 32'(tick),        32'd0);
    check({tag, ".wrap"}, 32'(wrap),        32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    int exp_up[5];
    int exp_dn[5];
    int exp_ps[9];
    exp_up = '{1, 2, 3, 0, 1};
    exp_dn = '{2, 1, 0, 2, 1};
    exp_ps = '{0, 0, 1, 1, 1, 2, 2, 2, 3};

    rst = 1'b1; en = 1'b0; count_reset = 1'b0; upnotdown = 1'b1;
    period = 16'd3; prescale = 8'd0;
`ifdef PWM_COUNTER_ONESHOT_EN
    oneshot = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset.cnt",  32'(counter_val), 32'd0);
    check("reset.tick", 32'(tick),        32'd0);
    check("reset.wrap", 32'(wrap),        32'd0);
    rst = 1'b0;
    model_clear();

    // Up count, prescale 0
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step("up");
      check("up.seq", 32'(counter_val), 32'(exp_up[i]));
    end

    // Prescaler: one step per 3 clocks
    period = 16'd5; prescale = 8'd2; count_reset = 1'b1;
    step("psc.clr");
    count_reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step("psc");
      check("psc.seq", 32'(counter_val), 32'(exp_ps[i]));
    end

    // Freeze and resume in phase
    en = 1'b0;
    steps(5, "freeze");
    en = 1'b1;
    steps(4, "resume");

    // count_reset in up mode at 7
    period = 16'd9; prescale = 8'd0; count_reset = 1'b1;
    step("crst.prep");
    count_reset = 1'b0;
    steps(7, "crst.run");
    check("crst.at7", 32'(counter_val), 32'd7);
    count_reset = 1'b1;
    step("crst.up");
    check("crst.up0",  32'(counter_val), 32'd0);
    check("crst.wrap", 32'(wrap),        32'd0);

    // count_reset in down mode loads period, even with en low
    upnotdown = 1'b0; en = 1'b0;
    step("crst.dn");
    check("crst.dn9", 32'(counter_val), 32'd9);
    count_reset = 1'b0; en = 1'b1;

    // Period shrink, up mode
    upnotdown = 1'b1; period = 16'd15; count_reset = 1'b1;
    step("shr.up.clr");
    count_reset = 1'b0;
    steps(10, "shr.up.run");
    period = 16'd4;
    step("shr.up");
    check("shr.up.cnt",  32'(counter_val), 32'd0);
    check("shr.up.wrap", 32'(wrap),        32'd1);

    // Period shrink, down mode
    upnotdown = 1'b0; period = 16'd15; count_reset = 1'b1;
    step("shr.dn.clr");
    count_reset = 1'b0;
    steps(5, "shr.dn.run");
    period = 16'd4;
    step("shr.dn");
    check("shr.dn.cnt",  32'(counter_val), 32'd4);
    check("shr.dn.wrap", 32'(wrap),        32'd1);

    // Direction change mid-run, no reload
    period = 16'd9; upnotdown = 1'b1;
    steps(2, "dir.up");
    upnotdown = 1'b0;
    step("dir.dn");
    check("dir.dn.cnt", 32'(counter_val), 32'd5);

    // period = 0: every step wraps at 0
    period = 16'd0;
    steps(2, "p0.dn");
    upnotdown = 1'b1;
    steps(3, "p0.up");

    // Prescale lowered below the current phase
    period = 16'd9; prescale = 8'd5; count_reset = 1'b1;
    step("pl.clr");
    count_reset = 1'b0;
    steps(4, "pl.run");
    prescale = 8'd1;
    step("pl.step");
    check("pl.cnt",  32'(counter_val), 32'd1);
    check("pl.tick", 32'(tick),        32'd1);

    // prescale = 255: one step per 256 enabled clocks
    prescale = 8'd255; count_reset = 1'b1;
    step("p255.clr");
    count_reset = 1'b0;
    steps(255, "p255.run");
    check("p255.before", 32'(counter_val), 32'd0);
    step("p255.step");
    check("p255.after", 32'(counter_val), 32'd1);

    // Async reset at count 3 with prescaler mid-phase
    prescale = 8'd3; count_reset = 1'b1;
    step("ar.clr");
    count_reset = 1'b0;
    steps(14, "ar.run");
    check("ar.at3", 32'(counter_val), 32'd3);
    async_reset("ar");
    steps(4, "ar.restart");
    check("ar.restart.cnt", 32'(counter_val), 32'd1);

    // Down count from 0 after reset
    async_reset("dn.rst");
    period = 16'd2; prescale = 8'd0; upnotdown = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("dn");
      check("dn.seq", 32'(counter_val), 32'(exp_dn[i]));
    end

`ifdef PWM_COUNTER_ONESHOT_EN
    // One-shot: stop after the first wrap
    upnotdown = 1'b1; period = 16'd2; oneshot = 1'b1; count_reset = 1'b1;
    step("os.clr");
    count_reset = 1'b0;
    steps(5, "os.run");
    check("os.cnt",     32'(counter_val), 32'd0);
    check("os.stopped", 32'(stopped),     32'd1);
    count_reset = 1'b1;
    step("os.crst");
    check("os.cleared", 32'(stopped), 32'd0);
    count_reset = 1'b0; oneshot = 1'b0;
    steps(4, "os.cont");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_counter.md
Name: pwm_counter

Overview:
Timebase counter for the PWM generator. It consumes the programming outputs of the register block: period, en, count_reset, upnotdown and prescale. It produces the live counter_val, which the register block reads back at addresses 0x08/0x09 and the PWM output stage compares against compare1/compare2. It also produces per-step and per-wrap pulses for the PWM stage.

Parameters:
WIDTH, 16, counter and period width
PSC_W, 8, prescale field width

Ports:
clk  input  1  single system clock
rst  input  1  asynchronous reset, active-high
en  input  1  count enable; low freezes counter and prescaler
count_reset  input  1  synchronous one-cycle counter clear pulse
upnotdown  input  1  1 = count up, 0 = count down
period  input  WIDTH  terminal count, inclusive
prescale  input  PSC_W  step every prescale+1 enabled clocks
counter_val  output  WIDTH  current count, registered
tick  output  1  high for one cycle when counter_val has just stepped
wrap  output  1  high for one cycle when counter_val has just wrapped

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. On rst: counter_val=0, internal psc_cnt=0, tick=0, wrap=0. Reset mid-count aborts immediately, with no partial step.
- All other logic is synchronous to the rising edge of clk. All outputs are registered.
- Priority per edge, highest first: rst, then count_reset, then en.
- count_reset=1 (regardless of en):
  - counter_val <= upnotdown ? 0 : period
  - psc_cnt <= 0
  - tick=0, wrap=0 on the next cycle
- en=0: counter_val and psc_cnt hold; tick=wrap=0.
- en=1, psc_cnt < prescale: psc_cnt <= psc_cnt+1, no step.
- en=1, psc_cnt >= prescale: step; psc_cnt <= 0.
  - The >= comparison covers prescale being lowered below psc_cnt; the step then happens on the next enabled edge.
- Step, up mode: if counter_val >= period then counter_val <= 0 and wrap; else counter_val+1.
- Step, down mode: if counter_val == 0 or counter_val > period then counter_val <= period and wrap; else counter_val-1.
- Pulse timing: tick is 1 in the cycle where the new counter_val is first visible. wrap is a subset of tick.
- Latency: a step decision on edge N is visible on counter_val and tick after edge N.
- period=0: counter_val stays 0; every step is a wrap.
- upnotdown change mid-run: takes effect at the next step, with no reload.
- period change mid-run: takes effect at the next step comparison.
- Arithmetic is unsigned WIDTH bits. No overflow is possible, because the wrap rules bound the count to 0..period.
- Prescaler period is exactly prescale+1 enabled clocks. prescale=255 gives one step per 256 enabled clocks.

Optional Feature:
Macro PWM_COUNTER_ONESHOT_EN.
- Defined: adds input oneshot (1 bit) and output stopped (1 bit, reset 0).
  - When oneshot=1 and a wrap step occurs: counter_val takes the wrap value, tick=wrap=1 for that cycle, and stopped <= 1.
  - While stopped=1: counter_val and psc_cnt hold, and tick and wrap stay 0, even with en=1.
  - count_reset or rst clears stopped.
  - oneshot=0 gives continuous counting identical to the undefined build.
- Undefined: the oneshot and stopped ports and all related logic are absent. Counting is always continuous.

Test Plan:
- Up count: rst pulse, then period=3, prescale=0, upnotdown=1, en=1. Required: counter_val 1,2,3,0,1 on successive cycles; tick every cycle; wrap only with the 0.
- Prescaler: period=5, prescale=2, up. Required: counter_val changes every 3rd clock (0,0,0,1,1,1,2...); tick one cycle per change.
- Down count: period=2, down, prescale=0, starting from 0 after reset. Required: 2(wrap),1,0,2(wrap),1.
- Control edge cases:
  - en=0 for 5 cycles mid-run: counter_val and psc_cnt frozen, then resume from the same phase.
  - count_reset in up mode at counter_val=7: next cycle counter_val=0, wrap=0.
  - count_reset in down mode with period=9: next cycle counter_val=9.
- Period shrink: at counter_val=10, write period=4. Required: up mode → next step 0 with wrap; down mode → next step 4 with wrap.
- Async reset: assert rst between edges at counter_val=3 with prescaler mid-phase. Required: counter_val=0 immediately without a clock; counting restarts cleanly after rst drops. With PWM_COUNTER_ONESHOT_EN and oneshot=1, period=2: counter stops at 0 with stopped=1 after the first wrap.
